// File: rtl/result_stream_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : result_pkg                                                    |
// | Description: Shared types and helpers for the result stream buffer.        |
// |              DEF_DATA_W - default width of one result beat                 |
// |              result_beat_t - one FIFO entry {last, data}                   |
// |              level_w()  - width of an occupancy count for a given depth    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package result_pkg;

  localparam int DEF_DATA_W = 8;

  typedef struct packed {
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } result_beat_t;

  // Occupancy needs one bit more than the address so that "full" is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_stream_buffer_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sync_fifo                                                     |
// | Description: Single-clock first-word-fall-through FIFO. rdata shows the    |
// |              head entry combinationally. The caller qualifies push/pop;    |
// |              push while full is only legal together with pop.              |
// | Ports      : clk, rst (sync, active-high), push, pop, wdata[WIDTH],        |
// |              rdata[WIDTH], full, empty, level[log2(DEPTH)+1]               |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sync_fifo
  import result_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty when addresses match.
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; reset empties the FIFO through the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[ADDR_W-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule
`default_nettype wire

// File: rtl/result_stream_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : result_stream_buffer                                          |
// | Description: Absorbs non-stallable pipeline result beats into a FIFO and   |
// |              re-emits them on a valid/ready stream, tagging the last beat  |
// |              of every FRAME_LEN-beat frame. Beats arriving while full are  |
// |              dropped and flagged in the sticky overflow bit.               |
// | Ports      : clk, rst (sync, active-high)                                  |
// |              in_valid, in_data[DATA_W]          - pipeline result input    |
// |              out_valid, out_ready, out_data, out_last - output stream      |
// |              frame_done - pulse after the last input beat of a frame       |
// |              overflow, ovf_clr - sticky drop flag and its clear            |
// |              level      - FIFO occupancy                                   |
// |              frame_max, frame_cnt - per-frame stats (RESULT_STATS_EN only) |
// | Config     : `define RESULT_STATS_EN to add the frame statistics outputs.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module result_stream_buffer
  import result_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      frame_done,
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic [level_w(DEPTH)-1:0] level
`ifdef RESULT_STATS_EN
  ,
  output logic [DATA_W-1:0]         frame_max,
  output logic [15:0]               frame_cnt
`endif
);

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] beat_cnt;
  logic             beat_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [DATA_W:0]  head;

  assign beat_last = (beat_cnt == LAST_IDX);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push      = in_valid && (!fifo_full || pop);
  assign drop      = in_valid && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({beat_last, in_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign out_last = head[DATA_W];
  assign out_data = head[DATA_W-1:0];

  // Frame position follows the input side, so dropped beats still advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= in_valid && beat_last;
      if (in_valid) begin
        if (beat_last) beat_cnt <= '0;
        else           beat_cnt <= beat_cnt + 1'b1;
      end
      if (ovf_clr)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

`ifdef RESULT_STATS_EN
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] next_max;

  assign next_max = (in_data > run_max) ? in_data : run_max;

  // Published on the last beat's edge so the new value is visible alongside frame_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_max   <= '0;
      frame_max <= '0;
      frame_cnt <= '0;
    end else if (in_valid) begin
      if (beat_last) begin
        frame_max <= next_max;
        run_max   <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        run_max   <= next_max;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_stream_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_result_stream_buffer                                       |
// | Description: Directed self-checking bench for result_stream_buffer with    |
// |              default parameters (DATA_W=8, DEPTH=16, FRAME_LEN=64).        |
// |              Frame statistics are checked when RESULT_STATS_EN is defined. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_result_stream_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       frame_done;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic [4:0] level;
`ifdef RESULT_STATS_EN
  logic [7:0]  frame_max;
  logic [15:0] frame_cnt;
`endif

  result_stream_buffer #(
    .DATA_W    (8),
    .DEPTH     (16),
    .FRAME_LEN (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .level      (level)
`ifdef RESULT_STATS_EN
    ,
    .frame_max  (frame_max),
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         fd_cnt = 0;
  logic [8:0] rx[$];

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       exp_ovf;
    logic [4:0] exp_lvl;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; a beat is recorded as consumed when valid&&ready before the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    ovf_clr   = c;
    if (!rst && out_valid && out_ready) rx.push_back({out_last, out_data});
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx.delete();
    fd_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ovf_clr priority and full-FIFO push/pop, starting from 16 stored beats
    //               rst   v     d      r     c     ovf   lvl    valid
    tbl[0] = '{1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'h51, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd16, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 8'h52, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd15, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h53, 1'b1, 1'b0, 1'b1, 5'd15, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd15, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 8'h54, 1'b0, 1'b0, 1'b0, 5'd16, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0};

    // ---- 1: reset state and one full frame with out_ready high ----
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_done", frame_done, 0);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      if (i == 0) begin
        chk("t1_latency_valid", out_valid, 1);
        chk("t1_latency_data", out_data, 0);
      end
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_count", rx.size(), 64);
    for (int i = 0; i < 64 && i < rx.size(); i++) begin
      chk("t1_data", rx[i][7:0], i);
      chk("t1_last", rx[i][8], (i == 63) ? 1 : 0);
    end
    chk("t1_frame_done_cnt", fd_cnt, 1);
    chk("t1_overflow", overflow, 0);

    // ---- 2: overflow with out_ready low, then drain ----
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t2_level_full", level, 16);
    chk("t2_overflow", overflow, 1);
    chk("t2_head_stable", out_data, 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_count", rx.size(), 16);
    for (int i = 0; i < 16 && i < rx.size(); i++) chk("t2_data", rx[i], i);
    chk("t2_level_empty", level, 0);
    chk("t2_overflow_sticky", overflow, 1);

    // ---- 3: push and pop on a full FIFO ----
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t3_level_pre", level, 16);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t3_level_post", level, 16);
    chk("t3_no_overflow", overflow, 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_count", rx.size(), 17);
    for (int i = 0; i < 16 && i < rx.size(); i++) chk("t3_older", rx[i], i);
    if (rx.size() > 16) chk("t3_aa_last", rx[16], 9'h0AA);

    // ---- 4: reset mid-frame restarts frame counting ----
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    do_reset();
    chk("t4_level_post_rst", level, 0);
    chk("t4_valid_post_rst", out_valid, 0);
    for (int i = 0; i < 64; i++) cycle(1'b1, 8'(i + 100), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_count", rx.size(), 64);
    for (int i = 0; i < 64 && i < rx.size(); i++)
      chk("t4_beat", rx[i], {(i == 63) ? 1'b1 : 1'b0, 8'(i + 100)});
    chk("t4_frame_done_cnt", fd_cnt, 1);

    // ---- 5: table-driven overflow clear / full-FIFO corner cases ----
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst;
      cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
      rst = 1'b0;
      chk($sformatf("t5_ovf[%0d]", i), overflow, tbl[i].exp_ovf);
      chk($sformatf("t5_lvl[%0d]", i), level, tbl[i].exp_lvl);
      chk($sformatf("t5_valid[%0d]", i), out_valid, tbl[i].exp_valid);
    end

`ifdef RESULT_STATS_EN
    // ---- 6: per-frame maximum and frame counter ----
    do_reset();
    chk("t6_max_rst", frame_max, 0);
    chk("t6_cnt_rst", frame_cnt, 0);
    for (int i = 0; i < 64; i++) cycle(1'b1, (i == 20) ? 8'h7F : 8'(i % 16), 1'b1, 1'b0);
    chk("t6_max_f1", frame_max, 8'h7F);
    chk("t6_cnt_f1", frame_cnt, 1);
    for (int i = 0; i < 64; i++) cycle(1'b1, (i == 40) ? 8'h12 : 8'(i % 16), 1'b1, 1'b0);
    chk("t6_max_f2", frame_max, 8'h12);
    chk("t6_cnt_f2", frame_cnt, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
